// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read, registered flags/count, sticky errors.
// Flags lag the causing edge by one cycle; writes when full and reads when empty are dropped and flagged.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_TH      = (1 << ADDR_WIDTH) - 2,
  parameter int AE_TH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH + 1)'(AF_TH);
  localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH + 1)'(AE_TH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_acc;
  logic                  rd_acc;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc)
      count_next = count + CNT_ONE;
    else if (rd_acc && !wr_acc)
      count_next = count - CNT_ONE;
  end

  // Flags come from count_next so they never depend combinationally on wr_en/rd_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc)
        rd_ptr <= rd_ptr + PTR_ONE;
      count        <= count_next;
      full         <= (count_next == DEPTH_LVL);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_LVL);
      almost_empty <= (count_next <= AE_LVL);
      if (wr_en && full)
        overflow <= 1'b1;
      else if (err_clr)
        overflow <= 1'b0;
      if (rd_en && empty)
        underflow <= 1'b1;
      else if (err_clr)
        underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst)
      mem[wr_ptr] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = mem[rd_ptr];
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (rst)
          rd_data <= '0;
        else if (rd_acc)
          rd_data <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench: a standard and an FWFT instance share one randomized stimulus stream,
// checked against a queue model of the FIFO's rules.
module tb_sync_fifo;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int AF_TH = DEPTH - 2;
  localparam int AE_TH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;

  logic          full_s, afull_s, empty_s, aempty_s, ovf_s, unf_s;
  logic [DW-1:0] rd_data_s;
  logic [AW:0]   count_s;
  logic          full_f, afull_f, empty_f, aempty_f, ovf_f, unf_f;
  logic [DW-1:0] rd_data_f;
  logic [AW:0]   count_f;

  int n_chk  = 0;
  int n_pass = 0;

  int model_q[$];
  int exp_q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AF_TH(AF_TH), .AE_TH(AE_TH)) u_std (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full_s),
    .almost_full(afull_s), .rd_en(rd_en), .rd_data(rd_data_s), .empty(empty_s),
    .almost_empty(aempty_s), .count(count_s), .overflow(ovf_s), .underflow(unf_s),
    .err_clr(err_clr)
  );

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AF_TH(AF_TH), .AE_TH(AE_TH)) u_fwft (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full_f),
    .almost_full(afull_f), .rd_en(rd_en), .rd_data(rd_data_f), .empty(empty_f),
    .almost_empty(aempty_f), .count(count_f), .overflow(ovf_f), .underflow(unf_f),
    .err_clr(err_clr)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_state();
    int n;
    n = model_q.size();
    chk("count", int'(count_s), n);
    chk("empty", int'(empty_s), int'(n == 0));
    chk("full", int'(full_s), int'(n == DEPTH));
    chk("almost_full", int'(afull_s), int'(n >= AF_TH));
    chk("almost_empty", int'(aempty_s), int'(n <= AE_TH));
    chk("overflow", int'(ovf_s), int'(m_ovf));
    chk("underflow", int'(unf_s), int'(m_unf));
    chk("fwft_count", int'(count_f), n);
    chk("fwft_empty", int'(empty_f), int'(n == 0));
    chk("fwft_flags", int'({full_f, afull_f, aempty_f, ovf_f, unf_f}),
        int'({n == DEPTH, n >= AF_TH, n <= AE_TH, m_ovf, m_unf}));
    if (n > 0)
      chk("fwft_head", int'(rd_data_f), model_q[0]);
  endtask

  // One clock of stimulus; called with the bench sitting on a falling edge.
  task automatic step(input bit we, input bit re, input int d, input bit clr, input bit r);
    bit wacc, racc;
    wr_en   = we;
    rd_en   = re;
    wr_data = d[DW-1:0];
    err_clr = clr;
    rst     = r;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      wacc = we && (model_q.size() < DEPTH);
      racc = re && (model_q.size() > 0);
      if (we && model_q.size() == DEPTH) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (re && model_q.size() == 0) m_unf = 1'b1;
      else if (clr) m_unf = 1'b0;
      if (racc) exp_q.push_back(model_q.pop_front());
      if (wacc) model_q.push_back(d & 16'hFFFF);
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic wr(input int d);
    step(1'b1, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && model_q.size() > 0; i++) rd();
  endtask

  // Monitor: every read the DUT accepts produces a word one cycle later.
  always @(posedge clk) begin
    if (rd_en && !empty_s && !rst) begin
      @(negedge clk);
      chk("sb_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0)
        chk("rd_data", int'(rd_data_s), exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    chk("reset_rd_data", int'(rd_data_s), 0);
    idle();

    // basic write/read
    wr(16'h1234); wr(16'h0000); wr(16'h0001);
    rd(); rd(); rd(); idle();

    // fill, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) wr(i);
    wr(16'hBEEF);
    drain(); idle();
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);

    // wrap-around
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) wr(16'h0100 + k * 10 + i);
      for (int i = 0; i < 10; i++) rd();
    end
    idle();

    // simultaneous read+write at 16, 5, 0
    for (int i = 0; i < DEPTH; i++) wr(16'h0200 + i);
    step(1'b1, 1'b1, 16'h0BAD, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    while (model_q.size() > 5) rd();
    step(1'b1, 1'b1, 16'h0300, 1'b0, 1'b0);
    drain();
    step(1'b1, 1'b1, 16'h0400, 1'b0, 1'b0);
    rd(); idle();
    // set beats clear in the same cycle
    step(1'b0, 1'b1, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);

    // FWFT head visible with no rd_en, consumed by one rd_en
    wr(16'hA5A5); idle(); rd(); idle();

    // reset mid-operation at count 7
    for (int i = 0; i < 7; i++) wr(16'h0500 + i);
    rd(); rd(); wr(16'h0600); wr(16'h0601);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    wr(16'h0042); rd(); idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, c;
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 39) == 0);
      if (i % 600 < 300)
        step($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 40, int'($urandom), c, r);
      else
        step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 65, int'($urandom), c, r);
    end

    drain(); idle(); idle();
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Parametrised single-clock FIFO for the echo datapath. It is the next generation of our two-clock FIFO, used wherever producer and consumer share one clock (sample delay lines, echo tap buffers).
Beyond the two-clock FIFO, it adds:
- selectable standard or first-word-fall-through (FWFT) read mode
- occupancy count
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags

Parameters:
DATA_WIDTH, 16, width of the data word
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries
FWFT, 0, 0 = registered read (data one cycle after rd_en); 1 = head word presented while !empty
AF_TH, DEPTH-2, almost_full asserted when count >= AF_TH; legal range 1..DEPTH
AE_TH, 2, almost_empty asserted when count <= AE_TH; legal range 0..DEPTH-1

Ports:
clk  in  1  single clock, all logic on the rising edge
rst  in  1  synchronous, active-high reset
wr_data  in  DATA_WIDTH  write word
wr_en  in  1  write request
full  out  1  no space; writes are rejected
almost_full  out  1  count >= AF_TH
rd_en  in  1  read request (pop/acknowledge in FWFT mode)
rd_data  out  DATA_WIDTH  read word
empty  out  1  no data; reads are rejected
almost_empty  out  1  count <= AE_TH
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty
err_clr  in  1  clears overflow and underflow

Behaviour:
- Interface: one clock (clk) and a synchronous, active-high reset (rst). Reset is sampled only on a rising edge of clk.
- Reset values: wr_ptr = rd_ptr = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0, rd_data = 0 (FWFT = 0). Memory contents are not cleared.
- Reset mid-operation: all stored words are discarded. The first write after reset lands at address 0.
- Write accept: wr_acc = wr_en && !full. On accept, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read accept: rd_acc = rd_en && !empty. On accept, rd_ptr increments.
- Flag sampling: full and empty are the registered values at the edge.
- Pointer wrap: pointers are ADDR_WIDTH bits wide and wrap naturally from DEPTH-1 to 0. Full and empty are derived from count, never from pointer comparison.
- Count update: count_next = count + wr_acc - rd_acc.
  - Simultaneous accepted read and write: count is unchanged, both pointers advance.
- Simultaneous read and write while full: the read is accepted, the write is rejected and overflow sets.
- Simultaneous read and write while empty: the write is accepted, the read is rejected and underflow sets. There is no bypass.
- Flag registration: full, empty, almost_full, almost_empty and count are all registered from count_next. They change one cycle after the causing edge, with no combinational paths from wr_en or rd_en.
- FWFT = 0 read path:
  - On rd_acc, rd_data <= mem[rd_ptr]; the word is valid the cycle after the accepting edge.
  - rd_data holds its value when no read is accepted.
- FWFT = 1 read path:
  - rd_data = mem[rd_ptr], valid whenever empty = 0.
  - rd_en asserted with !empty consumes the displayed word; the next word appears the following cycle.
  - rd_data is don't-care while empty.
- Write-to-visible latency: one cycle after the write edge (empty falls). With FWFT = 1, the head word is valid in that same cycle.
- Error flags:
  - overflow sets on wr_en && full; underflow sets on rd_en && empty.
  - Both flags are cleared by rst or by err_clr.
  - If a set condition and err_clr occur in the same cycle, set wins.
- Rejected operations: no pointer, count or memory change.

Test Plan:
- Reset, then write 0x1234, 0x0000, 0x0001 on consecutive cycles, then read 3 (FWFT = 0):
  - empty falls 1 cycle after the first write edge; count reaches 3.
  - rd_data is 0x1234, 0x0000, 0x0001, each 1 cycle after its rd_en edge.
  - empty = 1 and count = 0 at the end.
- Fill to 16 (ADDR_WIDTH = 4) with 0x0000..0x000F, then attempt a 17th write of 0xBEEF:
  - full = 1 and almost_full = 1 (asserted from count 14).
  - count = 16; overflow = 1; 0xBEEF is not stored.
  - Draining yields 0x0000..0x000F in order.
- Wrap-around: write 10, read 10, write 10, read 10 with an incrementing pattern:
  - All 20 words come out in order; no flag errors.
  - almost_empty = 1 exactly when count <= 2.
- Simultaneous read+write at count = 16, at count = 5 and at count = 0:
  - At 16: count 15, overflow sets.
  - At 5: count stays 5.
  - At 0: count 1, underflow sets.
- FWFT = 1: write 0xA5A5:
  - rd_data = 0xA5A5 in the cycle empty falls, with no rd_en required.
  - rd_en for one cycle: empty = 1 next cycle.
- Reset mid-operation at count = 7: the next cycle shows count = 0, empty = 1, overflow = 0 and underflow = 0. A following write of 0x0042 reads back as 0x0042.
